// File: rtl/dht11_bin2bcd.sv
`default_nettype none
// ============================================================================
// Module   : dht11_bin2bcd
// Purpose  : Sequential binary-to-BCD converter placed directly after the
//            DHT11 sensor front end. On a conversion strobe it captures the
//            humidity/temperature word and converts both bytes in parallel
//            with shift-and-add-3 (double dabble). Results are presented as
//            two registered DIG_NUM-digit BCD values with a one-cycle valid.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   BYTE_SZ  - width of each binary field (humidity, temperature)
//   VALUE_SZ - width of the input word (2*BYTE_SZ)
//   DIG_NUM  - BCD digits per field; 10**DIG_NUM must exceed 2**BYTE_SZ-1
//   BCD_SZ   - width of each BCD output (4*DIG_NUM)
// Ports:
//   CLK        in   system clock (50 MHz)
//   RST_n      in   asynchronous active-low reset
//   I_CONV     in   single-cycle conversion request from the front end
//   I_VALUE    in   sensor word: [VALUE_SZ-1:BYTE_SZ] humidity,
//                   [BYTE_SZ-1:0] temperature
//   I_ERR      in   front-end error flag, sampled together with I_CONV
//   O_BCD_HUM  out  humidity BCD, most significant digit in the top nibble
//   O_BCD_TEMP out  temperature BCD, same layout
//   O_VALID    out  one-cycle pulse: results and O_ERR have been updated
//   O_BUSY     out  high while a conversion is in progress
//   O_ERR      out  error status of the last completed request
// ============================================================================
module dht11_bin2bcd #(
  parameter int BYTE_SZ  = 8,
  parameter int VALUE_SZ = 2 * BYTE_SZ,
  parameter int DIG_NUM  = 3,
  parameter int BCD_SZ   = 4 * DIG_NUM
) (
  input  logic                CLK,
  input  logic                RST_n,
  input  logic                I_CONV,
  input  logic [VALUE_SZ-1:0] I_VALUE,
  input  logic                I_ERR,
  output logic [BCD_SZ-1:0]   O_BCD_HUM,
  output logic [BCD_SZ-1:0]   O_BCD_TEMP,
  output logic                O_VALID,
  output logic                O_BUSY,
  output logic                O_ERR
);

  // Counter must be able to hold the value BYTE_SZ without wrapping.
  localparam int CNT_W = $clog2(BYTE_SZ + 1);
  localparam int CAT_W = BCD_SZ + BYTE_SZ;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BYTE_SZ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [BYTE_SZ-1:0]  hum_bin_q, hum_bin_d;
  logic [BYTE_SZ-1:0]  temp_bin_q, temp_bin_d;
  logic [BCD_SZ-1:0]   hum_scr_q, hum_scr_d;
  logic [BCD_SZ-1:0]   temp_scr_q, temp_scr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;

  // Output registers
  logic [BCD_SZ-1:0]   bcd_hum_q, bcd_hum_d;
  logic [BCD_SZ-1:0]   bcd_temp_q, bcd_temp_d;
  logic                valid_q, valid_d;
  logic                err_out_q, err_out_d;

  // --------------------------------------------------------------------------
  // Double-dabble digit correction: every digit >= 5 gets +3 before the shift
  // so that the shift carries it correctly into the next decimal digit.
  // Each nibble is corrected on its own; no carry crosses digit boundaries.
  // --------------------------------------------------------------------------
  logic [BCD_SZ-1:0] hum_adj;
  logic [BCD_SZ-1:0] temp_adj;

  for (genvar d = 0; d < DIG_NUM; d++) begin : g_dig
    assign hum_adj[4*d +: 4]  = (hum_scr_q[4*d +: 4] >= 4'd5)
                              ? (hum_scr_q[4*d +: 4] + 4'd3)
                              : hum_scr_q[4*d +: 4];
    assign temp_adj[4*d +: 4] = (temp_scr_q[4*d +: 4] >= 4'd5)
                              ? (temp_scr_q[4*d +: 4] + 4'd3)
                              : temp_scr_q[4*d +: 4];
  end

  // {scratch, binary} shifted left by one as a single vector; the binary MSB
  // moves into the scratch LSB.
  logic [CAT_W-1:0] hum_cat;
  logic [CAT_W-1:0] temp_cat;

  assign hum_cat  = {hum_adj, hum_bin_q} << 1;
  assign temp_cat = {temp_adj, temp_bin_q} << 1;

  // --------------------------------------------------------------------------
  // Next-state and datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    hum_bin_d  = hum_bin_q;
    temp_bin_d = temp_bin_q;
    hum_scr_d  = hum_scr_q;
    temp_scr_d = temp_scr_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    bcd_hum_d  = bcd_hum_q;
    bcd_temp_d = bcd_temp_q;
    err_out_d  = err_out_q;
    valid_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (I_CONV) begin
          hum_bin_d  = I_VALUE[VALUE_SZ-1:BYTE_SZ];
          temp_bin_d = I_VALUE[BYTE_SZ-1:0];
          err_d      = I_ERR;
          hum_scr_d  = '0;
          temp_scr_d = '0;
          cnt_d      = '0;
          state_d    = S_SHIFT;
        end
      end

      S_SHIFT: begin
        hum_scr_d  = hum_cat[CAT_W-1:BYTE_SZ];
        hum_bin_d  = hum_cat[BYTE_SZ-1:0];
        temp_scr_d = temp_cat[CAT_W-1:BYTE_SZ];
        temp_bin_d = temp_cat[BYTE_SZ-1:0];
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        // A flagged request still takes the full latency but leaves the
        // previously published BCD values untouched.
        if (!err_q) begin
          bcd_hum_d  = hum_scr_q;
          bcd_temp_d = temp_scr_q;
        end
        err_out_d = err_q;
        valid_d   = 1'b1;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q    <= S_IDLE;
      hum_bin_q  <= '0;
      temp_bin_q <= '0;
      hum_scr_q  <= '0;
      temp_scr_q <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      bcd_hum_q  <= '0;
      bcd_temp_q <= '0;
      valid_q    <= 1'b0;
      err_out_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hum_bin_q  <= hum_bin_d;
      temp_bin_q <= temp_bin_d;
      hum_scr_q  <= hum_scr_d;
      temp_scr_q <= temp_scr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      bcd_hum_q  <= bcd_hum_d;
      bcd_temp_q <= bcd_temp_d;
      valid_q    <= valid_d;
      err_out_q  <= err_out_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign O_BCD_HUM  = bcd_hum_q;
  assign O_BCD_TEMP = bcd_temp_q;
  assign O_VALID    = valid_q;
  assign O_ERR      = err_out_q;
  assign O_BUSY     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: doc/dht11_bin2bcd.md
# dht11_bin2bcd

Sequential binary-to-BCD converter that sits directly downstream of the DHT11 sensor front end. On the front end's conversion strobe it captures the 2-byte humidity/temperature word and converts each byte in parallel using shift-and-add-3 (double dabble). It presents two registered 3-digit BCD results with a one-cycle valid pulse to the display/UART stage.

## Interface
- BYTE_SZ, 8, width of each binary field
- VALUE_SZ, 2*BYTE_SZ, width of the input word
- DIG_NUM, 3, BCD digits per field
  - Must satisfy 10^DIG_NUM > 2^BYTE_SZ − 1.
- BCD_SZ, 4*DIG_NUM, width of each BCD output (derived)

Ports:
- CLK  in  1  system clock, 50 MHz
- RST_n  in  1  asynchronous, active-low reset
- I_CONV  in  1  conversion request strobe; single-cycle from the front end's O_CONV
- I_VALUE  in  VALUE_SZ  sensor word
  - [VALUE_SZ-1:BYTE_SZ] is humidity integer.
  - [BYTE_SZ-1:0] is temperature integer.
- I_ERR  in  1  front end's error flag, sampled with I_CONV
- O_BCD_HUM  out  BCD_SZ  humidity BCD, most significant digit in the top nibble
- O_BCD_TEMP  out  BCD_SZ  temperature BCD, same layout
- O_VALID  out  1  one-cycle pulse; results and O_ERR updated
- O_BUSY  out  1  high while a conversion is in progress
- O_ERR  out  1  error status of the last completed request

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE, I_CONV=1:
  - Capture both bytes into shift registers.
  - Capture I_ERR into err_q.
  - Clear both BCD scratch registers and the bit counter.
  - Go to SHIFT.
- I_CONV in any state other than IDLE is ignored. There is no queueing.
- SHIFT: one iteration per clock, applied to both fields independently.
  - Any scratch digit ≥ 5 gets +3 (4-bit add, no carry between digits).
  - Shift {scratch, binary} left by 1.
  - Increment the counter.
  - After the BYTE_SZ-th iteration, go to DONE.
- DONE:
  - If err_q=0, load O_BCD_HUM/O_BCD_TEMP from scratch. If err_q=1, BCD outputs keep their previous values.
  - O_ERR <= err_q.
  - O_VALID <= 1 for exactly one cycle.
  - Go to IDLE.
- O_BUSY = (state != IDLE).
- Conversion always runs the full BYTE_SZ iterations, including when I_ERR=1, so latency is constant.
- Counter width is ceil(log2(BYTE_SZ+1)). The counter never wraps within a conversion.
- Reset (asynchronous, any time, including mid-SHIFT):
  - State goes to IDLE; the in-flight conversion is discarded.
  - All outputs go to 0: O_BCD_HUM, O_BCD_TEMP, O_VALID, O_BUSY, O_ERR.
  - Scratch, shift registers, counter and err_q go to 0.

## Timing
- Capture edge k: I_CONV=1 in IDLE.
  - O_BUSY is 1 from the cycle after edge k.
  - Edges k+1 … k+BYTE_SZ perform the iterations.
  - Edge k+BYTE_SZ+1 is the DONE→IDLE edge: outputs load and O_VALID rises.
  - O_BUSY falls on the same edge.
- Request-to-valid latency: BYTE_SZ+1 clocks (9 with defaults).
- The O_VALID cycle is IDLE, so an I_CONV in that same cycle is accepted: back-to-back period is BYTE_SZ+1 clocks.
- I_VALUE and I_ERR only need to be stable in the capture cycle.
- Outputs are held stable between O_VALID pulses.

## Test plan
- Basic conversion: reset, then I_VALUE=0x2A17, I_ERR=0, one-cycle I_CONV.
  - O_VALID pulses exactly 9 cycles later.
  - O_BCD_HUM=0x042, O_BCD_TEMP=0x023, O_ERR=0.
  - O_BUSY is high for exactly 9 cycles.
- Extremes: I_VALUE=0xFF00 → HUM=0x255, TEMP=0x000. Then I_VALUE=0x6309 → HUM=0x099, TEMP=0x009.
- Error hold: convert 0x2A17 cleanly, then request 0x5050 with I_ERR=1.
  - O_VALID pulses.
  - O_ERR=1; BCD outputs stay 0x042/0x023.
  - A following clean request clears O_ERR to 0.
- Ignored request: assert I_CONV with 0x1111 three cycles into a 0x2A17 conversion.
  - Only one O_VALID occurs, with 0x042/0x023.
  - No second conversion follows.
- Back-to-back: assert I_CONV (0x0C22) in the O_VALID cycle of a prior conversion.
  - Second O_VALID follows exactly 9 cycles later with HUM=0x012, TEMP=0x034.
- Reset mid-SHIFT: assert RST_n=0 at iteration 4.
  - All outputs are 0 immediately.
  - No O_VALID after release.
  - The next request converts correctly.
